// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer/count width helpers for sync_fifo
package fifo_pkg;
  function automatic int ptr_w(int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic int cnt_w(int depth);
    return ptr_w(depth);
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x T storage, sync write port (we/waddr/wdata), async read port (raddr->rdata)
module fifo_mem #(
  parameter type T = logic [31:0],
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  T              wdata,
  input  logic [AW-1:0] raddr,
  output T              rdata
);
  T mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FWFT circular FIFO; push/pop handshakes, occupancy flags, sticky over/underflow
module sync_fifo
  import fifo_pkg::*;
#(
  parameter type T = logic [31:0],
  parameter int DEPTH = 8,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_en,
  input  T                         write_data,
  input  logic                     read_en,
  output T                         read_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE = PW'(AE_THRESH);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  T rdata;
  // MSB is the wrap bit: equal low bits with differing wrap bits means full
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign empty = wr_ptr == rd_ptr;
  assign count = wr_ptr - rd_ptr;
  assign almost_full = count >= AF;
  assign almost_empty = count <= AE;
  assign push = write_en && !full;
  assign pop = read_en && !empty;
  assign read_data = empty ? '0 : rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      overflow <= overflow | (write_en & full);
      underflow <= underflow | (read_en & empty);
    end
  end
  fifo_mem #(.T(T), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk),
    .we(push && !rst),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(write_data),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rdata)
  );
  always @(posedge clk) begin
    assert (count <= PW'(DEPTH));
    assert ((DEPTH & (DEPTH - 1)) == 0 && DEPTH >= 2);
    assert (AF_THRESH <= DEPTH);
  end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo (DEPTH=8, AF_THRESH=6, AE_THRESH=1)
module tb_sync_fifo;
  logic clk = 0, rst = 0, write_en = 0, read_en = 0;
  logic [31:0] write_data = '0, read_data;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  sync_fifo #(.DEPTH(8), .AF_THRESH(6), .AE_THRESH(1)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .read_data(read_data), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive(input logic we, input logic [31:0] wd, input logic re);
    write_en = we;
    write_data = wd;
    read_en = re;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1;
    tick();
    rst = 0;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1, i, 0);
      tick();
      chk("fill_count", count, i + 1);
      chk("fill_head", read_data, 0);
      chk("fill_af", almost_full, (i + 1) >= 6);
      chk("fill_ae", almost_empty, (i + 1) <= 1);
    end
    chk("fill_full", full, 1);
    drive(1, 99, 0);
    tick();
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 8);
    drive(1, 99, 1);
    chk("ovf_pop_head", read_data, 0);
    tick();
    chk("ovf_pop_count", count, 7);
    for (int i = 1; i < 8; i++) begin
      drive(0, 0, 1);
      chk("drain_data", read_data, i);
      tick();
    end
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    chk("drain_rdata", read_data, 0);
    drive(0, 0, 1);
    tick();
    chk("unf_flag", underflow, 1);
    chk("unf_count", count, 0);
    drive(1, 5, 1);
    tick();
    chk("unf_sticky", underflow, 1);
    chk("unf_push_count", count, 1);
    chk("unf_push_data", read_data, 5);
    drive(0, 0, 1);
    tick();
    chk("unf_pop_empty", empty, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 100 + i, 0);
      tick();
    end
    chk("stream_prefill", count, 4);
    for (int k = 0; k < 50; k++) begin
      drive(1, 104 + k, 1);
      chk("stream_data", read_data, 100 + k);
      tick();
      chk("stream_count", count, 4);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1);
      chk("stream_tail", read_data, 150 + k);
      tick();
    end
    chk("stream_empty", empty, 1);
    for (int i = 0; i < 9; i++) begin
      drive(1, 200 + i, 0);
      tick();
    end
    chk("mid_ovf", overflow, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1);
      tick();
    end
    chk("mid_count", count, 5);
    rst = 1;
    drive(1, 77, 0);
    tick();
    rst = 0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_unf", underflow, 0);
    drive(1, 42, 0);
    tick();
    drive(0, 0, 0);
    chk("post_rst_data", read_data, 42);
    chk("post_rst_count", count, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
